// File: rtl/vga_pkg.sv
// Shared VGA timing constants, widths and the aligned pixel bus payload.
// Defaults describe the 640x480 raster; transmitter and receiver agree on these.
package vga_pkg;

  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FRONT   = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BACK    = 48;
  localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FRONT   = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BACK    = 33;
  localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Sync windows, inclusive bounds in raster counts
  localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
  localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
  localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
  localparam int unsigned VS_END   = VS_START + V_SYNC - 1;

  localparam int unsigned WIDTH_BITS  = 10;
  localparam int unsigned HEIGHT_BITS = 9;
  localparam int unsigned PIXEL_BITS  = 12;
  localparam int unsigned CNT_BITS    = 10;

  typedef struct packed {
    logic [WIDTH_BITS-1:0]  x;
    logic [HEIGHT_BITS-1:0] y;
    logic [PIXEL_BITS-1:0]  pixel;
    logic                   video_on;
    logic                   h_sync;
    logic                   v_sync;
  } vga_bus_t;

endpackage

// File: rtl/vga_pixel_transmitter_if.sv
// Pixel-source / display-path bundle of the VGA transmitter.
// master: transmitter side (drives fetch address and the aligned output bundle).
// slave : source/receiver side (drives enable and fetched pixel data).
interface vga_pixel_transmitter_if #(
  parameter int unsigned WIDTH_BITS  = vga_pkg::WIDTH_BITS,
  parameter int unsigned HEIGHT_BITS = vga_pkg::HEIGHT_BITS,
  parameter int unsigned PIXEL_BITS  = vga_pkg::PIXEL_BITS
);

  logic                   enable_in;
  logic [WIDTH_BITS-1:0]  fetch_x_out;
  logic [HEIGHT_BITS-1:0] fetch_y_out;
  logic [PIXEL_BITS-1:0]  pixel_data_in;
  logic [WIDTH_BITS-1:0]  pixel_x_out;
  logic [HEIGHT_BITS-1:0] pixel_y_out;
  logic [PIXEL_BITS-1:0]  pixel_out;
  logic                   video_on_out;
  logic                   h_sync_out;
  logic                   v_sync_out;
  logic                   pixel_tick_out;
  logic                   frame_start_out;

  modport master (
    input  enable_in, pixel_data_in,
    output fetch_x_out, fetch_y_out, pixel_x_out, pixel_y_out, pixel_out,
           video_on_out, h_sync_out, v_sync_out, pixel_tick_out, frame_start_out
  );

  modport slave (
    output enable_in, pixel_data_in,
    input  fetch_x_out, fetch_y_out, pixel_x_out, pixel_y_out, pixel_out,
           video_on_out, h_sync_out, v_sync_out, pixel_tick_out, frame_start_out
  );

endinterface

// File: rtl/vga_raster_counter.sv
// Pixel-clock divider plus horizontal/vertical raster counters.
// Ports: clk, rst_n, enable (low clears everything synchronously);
// tick_c (last clock of a pixel period), h_cnt/v_cnt (current position),
// h_nxt_c/v_nxt_c (position after this clock), h_wrap_c/v_wrap_c (line/frame end).
module vga_raster_counter #(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned H_TOTAL  = vga_pkg::H_TOTAL,
  parameter int unsigned V_TOTAL  = vga_pkg::V_TOTAL,
  parameter int unsigned CNT_BITS = vga_pkg::CNT_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  output logic                tick_c,
  output logic [CNT_BITS-1:0] h_cnt,
  output logic [CNT_BITS-1:0] v_cnt,
  output logic [CNT_BITS-1:0] h_nxt_c,
  output logic [CNT_BITS-1:0] v_nxt_c,
  output logic                h_wrap_c,
  output logic                v_wrap_c
);

  localparam int unsigned DIV_BITS = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_BITS-1:0] div_q;
  logic [DIV_BITS-1:0] div_nxt_c;

  // Next-state for divider and raster position
  always_comb begin
    tick_c    = enable && (div_q == DIV_BITS'(CLK_DIV - 1));
    h_wrap_c  = tick_c && (h_cnt == CNT_BITS'(H_TOTAL - 1));
    v_wrap_c  = h_wrap_c && (v_cnt == CNT_BITS'(V_TOTAL - 1));
    div_nxt_c = '0;
    h_nxt_c   = '0;
    v_nxt_c   = '0;
    if (enable) begin
      div_nxt_c = tick_c ? '0 : div_q + 1'b1;
      h_nxt_c   = h_cnt;
      v_nxt_c   = v_cnt;
      if (h_wrap_c) begin
        h_nxt_c = '0;
        v_nxt_c = v_wrap_c ? '0 : v_cnt + 1'b1;
      end else if (tick_c) begin
        h_nxt_c = h_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      div_q <= div_nxt_c;
      h_cnt <= h_nxt_c;
      v_cnt <= v_nxt_c;
    end
  end

endmodule

// File: rtl/vga_pixel_transmitter.sv
// VGA source-side timing generator and pixel driver.
// Ports: clock_in, reset_n_in (async active-low), bus (master modport):
// enable, fetch address out, fetched pixel in, and the aligned output bundle
// (pixel, coordinates, video_on, syncs, pixel tick, frame start).
// The output bundle lags the fetch address by exactly one pixel period.
module vga_pixel_transmitter import vga_pkg::*; #(
  parameter int unsigned H_VISIBLE   = vga_pkg::H_VISIBLE,
  parameter int unsigned H_FRONT     = vga_pkg::H_FRONT,
  parameter int unsigned H_SYNC      = vga_pkg::H_SYNC,
  parameter int unsigned H_BACK      = vga_pkg::H_BACK,
  parameter int unsigned V_VISIBLE   = vga_pkg::V_VISIBLE,
  parameter int unsigned V_FRONT     = vga_pkg::V_FRONT,
  parameter int unsigned V_SYNC      = vga_pkg::V_SYNC,
  parameter int unsigned V_BACK      = vga_pkg::V_BACK,
  parameter int unsigned WIDTH_BITS  = vga_pkg::WIDTH_BITS,
  parameter int unsigned HEIGHT_BITS = vga_pkg::HEIGHT_BITS,
  parameter int unsigned PIXEL_BITS  = vga_pkg::PIXEL_BITS,
  parameter int unsigned CLK_DIV     = 2
) (
  input  logic                     clock_in,
  input  logic                     reset_n_in,
  vga_pixel_transmitter_if.master  bus
);

  localparam int unsigned H_TOT    = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOT    = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_FIRST = H_VISIBLE + H_FRONT;
  localparam int unsigned HS_LAST  = HS_FIRST + H_SYNC - 1;
  localparam int unsigned VS_FIRST = V_VISIBLE + V_FRONT;
  localparam int unsigned VS_LAST  = VS_FIRST + V_SYNC - 1;

  logic                tick_c;
  logic                h_wrap_c;
  logic                v_wrap_c;
  logic [CNT_BITS-1:0] h_cnt;
  logic [CNT_BITS-1:0] v_cnt;
  logic [CNT_BITS-1:0] h_nxt_c;
  logic [CNT_BITS-1:0] v_nxt_c;

  vga_raster_counter #(
    .CLK_DIV  (CLK_DIV),
    .H_TOTAL  (H_TOT),
    .V_TOTAL  (V_TOT),
    .CNT_BITS (CNT_BITS)
  ) u_raster (
    .clk      (clock_in),
    .rst_n    (reset_n_in),
    .enable   (bus.enable_in),
    .tick_c   (tick_c),
    .h_cnt    (h_cnt),
    .v_cnt    (v_cnt),
    .h_nxt_c  (h_nxt_c),
    .v_nxt_c  (v_nxt_c),
    .h_wrap_c (h_wrap_c),
    .v_wrap_c (v_wrap_c)
  );

  logic vis_c;
  logic nxt_vis_c;
  logic hs_act_c;
  logic vs_act_c;
  logic origin_c;
  logic unused_wrap_c;

  // Region decode on the current position and on the position after this clock
  always_comb begin
    vis_c         = (h_cnt < CNT_BITS'(H_VISIBLE)) && (v_cnt < CNT_BITS'(V_VISIBLE));
    nxt_vis_c     = (h_nxt_c < CNT_BITS'(H_VISIBLE)) && (v_nxt_c < CNT_BITS'(V_VISIBLE));
    hs_act_c      = (h_cnt >= CNT_BITS'(HS_FIRST)) && (h_cnt <= CNT_BITS'(HS_LAST));
    vs_act_c      = (v_cnt >= CNT_BITS'(VS_FIRST)) && (v_cnt <= CNT_BITS'(VS_LAST));
    origin_c      = (h_cnt == '0) && (v_cnt == '0);
    unused_wrap_c = h_wrap_c ^ v_wrap_c;
  end

  logic [WIDTH_BITS-1:0]  fetch_x_q;
  logic [HEIGHT_BITS-1:0] fetch_y_q;
  logic [WIDTH_BITS-1:0]  x_q;
  logic [HEIGHT_BITS-1:0] y_q;
  logic [PIXEL_BITS-1:0]  pixel_q;
  logic                   video_on_q;
  logic                   h_sync_q;
  logic                   v_sync_q;
  logic                   pixel_tick_q;
  logic                   frame_start_q;

  // Fetch address is registered from the next raster position so it always
  // equals the decoded current position; the output stage loads on tick.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      fetch_x_q     <= '0;
      fetch_y_q     <= '0;
      x_q           <= '0;
      y_q           <= '0;
      pixel_q       <= '0;
      video_on_q    <= 1'b0;
      h_sync_q      <= 1'b1;
      v_sync_q      <= 1'b1;
      pixel_tick_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      fetch_x_q     <= nxt_vis_c ? WIDTH_BITS'(h_nxt_c) : '0;
      fetch_y_q     <= nxt_vis_c ? HEIGHT_BITS'(v_nxt_c) : '0;
      pixel_tick_q  <= tick_c;
      frame_start_q <= tick_c && origin_c;
      if (!bus.enable_in) begin
        x_q        <= '0;
        y_q        <= '0;
        pixel_q    <= '0;
        video_on_q <= 1'b0;
        h_sync_q   <= 1'b1;
        v_sync_q   <= 1'b1;
      end else if (tick_c) begin
        x_q        <= fetch_x_q;
        y_q        <= fetch_y_q;
        pixel_q    <= vis_c ? bus.pixel_data_in : '0;
        video_on_q <= vis_c;
        h_sync_q   <= !hs_act_c;
        v_sync_q   <= !vs_act_c;
      end
    end
  end

  assign bus.fetch_x_out     = fetch_x_q;
  assign bus.fetch_y_out     = fetch_y_q;
  assign bus.pixel_x_out     = x_q;
  assign bus.pixel_y_out     = y_q;
  assign bus.pixel_out       = pixel_q;
  assign bus.video_on_out    = video_on_q;
  assign bus.h_sync_out      = h_sync_q;
  assign bus.v_sync_out      = v_sync_q;
  assign bus.pixel_tick_out  = pixel_tick_q;
  assign bus.frame_start_out = frame_start_q;

endmodule

// File: tb/tb_vga_pixel_transmitter.sv
// Scoreboard bench: dut_a runs the full 640x480 timing at CLK_DIV=2 for a few
// lines; dut_b runs a scaled 16x8 raster at CLK_DIV=1 to cover whole frames.
module tb_vga_pixel_transmitter;
  import vga_pkg::*;

  typedef struct packed {
    vga_bus_t bus;
    logic     fs;
  } exp_t;

  localparam logic [63:0] RESET_OUTS = 64'h0000_0000_0000_000C;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  vga_pixel_transmitter_if ifa ();
  vga_pixel_transmitter_if ifb ();

  vga_pixel_transmitter dut_a (.clock_in(clk), .reset_n_in(rst_a), .bus(ifa.master));

  vga_pixel_transmitter #(
    .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(8),  .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .CLK_DIV(1)
  ) dut_b (.clock_in(clk), .reset_n_in(rst_b), .bus(ifb.master));

  int checks = 0;
  int passed = 0;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [11:0] quad(input int x, input int y, input int qx, input int qy);
    return ((x <= qx && y <= qy) || (x > qx && y > qy)) ? 12'hFFF : 12'h000;
  endfunction

  // Expected output for the i-th pixel period after enable
  function automatic exp_t model(input int i, input int htot, input int vtot,
                                 input int hvis, input int vvis, input int hs0, input int hs1,
                                 input int vs0, input int vs1, input int qx, input int qy);
    exp_t m;
    int h, v;
    logic vis;
    h   = i % htot;
    v   = (i / htot) % vtot;
    vis = (h < hvis) && (v < vvis);
    m.bus.x        = vis ? 10'(h) : 10'd0;
    m.bus.y        = vis ? 9'(v) : 9'd0;
    m.bus.pixel    = vis ? quad(h, v, qx, qy) : 12'h000;
    m.bus.video_on = vis;
    m.bus.h_sync   = !(h >= hs0 && h <= hs1);
    m.bus.v_sync   = !(v >= vs0 && v <= vs1);
    m.fs           = (h == 0) && (v == 0);
    return m;
  endfunction

  function automatic logic [63:0] outs_a();
    return 64'({ifa.fetch_x_out, ifa.fetch_y_out, ifa.pixel_x_out, ifa.pixel_y_out, ifa.pixel_out,
                ifa.video_on_out, ifa.h_sync_out, ifa.v_sync_out, ifa.pixel_tick_out, ifa.frame_start_out});
  endfunction

  function automatic logic [63:0] outs_b();
    return 64'({ifb.fetch_x_out, ifb.fetch_y_out, ifb.pixel_x_out, ifb.pixel_y_out, ifb.pixel_out,
                ifb.video_on_out, ifb.h_sync_out, ifb.v_sync_out, ifb.pixel_tick_out, ifb.frame_start_out});
  endfunction

  // Pixel sources: quadrant pattern addressed by the fetch coordinates
  always_comb ifa.pixel_data_in = quad(int'(ifa.fetch_x_out), int'(ifa.fetch_y_out), 320, 240);
  always_comb ifb.pixel_data_in = quad(int'(ifb.fetch_x_out), int'(ifb.fetch_y_out), 8, 4);

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  logic a_watch = 1'b0;
  logic b_watch = 1'b0;
  int a_vo = 0, a_hs_lo = 0;
  int b_no_tick = 0, b_tick_cnt = 0, b_last_fs = -1, b_gap = 0, b_vs_lo = 0;

  // Receiver A: compare every presented pixel against the scoreboard
  always @(negedge clk) begin
    if (a_watch && ifa.pixel_tick_out) begin
      if (qa.size() == 0) begin
        cmp("a_extra_tick", 64'(ifa.pixel_tick_out), 64'(0));
      end else begin
        ea = qa.pop_front();
        cmp($sformatf("a_px(%0d,%0d)", ea.bus.x, ea.bus.y),
            64'({ifa.pixel_x_out, ifa.pixel_y_out, ifa.pixel_out, ifa.video_on_out,
                 ifa.h_sync_out, ifa.v_sync_out, ifa.frame_start_out}), 64'(ea));
        a_vo    += int'(ifa.video_on_out);
        a_hs_lo += int'(!ifa.h_sync_out);
      end
    end
  end

  // Receiver B: scoreboard plus frame-level statistics
  always @(negedge clk) begin
    if (b_watch) begin
      if (!ifb.pixel_tick_out) b_no_tick++;
      else if (qb.size() == 0) begin
        cmp("b_extra_tick", 64'(ifb.pixel_tick_out), 64'(0));
      end else begin
        eb = qb.pop_front();
        cmp($sformatf("b_px(%0d,%0d)", eb.bus.x, eb.bus.y),
            64'({ifb.pixel_x_out, ifb.pixel_y_out, ifb.pixel_out, ifb.video_on_out,
                 ifb.h_sync_out, ifb.v_sync_out, ifb.frame_start_out}), 64'(eb));
        if (ifb.frame_start_out) begin
          if (b_last_fs >= 0) b_gap = b_tick_cnt - b_last_fs;
          b_last_fs = b_tick_cnt;
        end
        if (b_tick_cnt < 288 && !ifb.v_sync_out) b_vs_lo++;
        b_tick_cnt++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    ifa.enable_in = 1'b0; ifb.enable_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cmp("a_reset", outs_a(), RESET_OUTS);
    cmp("b_reset", outs_b(), RESET_OUTS);

    // ---- dut_a: first output, three partial lines, enable drop at (100,2)
    @(negedge clk);
    for (int i = 0; i < 1701; i++) qa.push_back(model(i, 800, 525, 640, 480, 656, 751, 490, 491, 320, 240));
    a_watch = 1'b1;
    rst_a = 1'b1;
    ifa.enable_in = 1'b1;
    @(posedge clk); #1;
    cmp("a_edge1_tick_fetch", 64'({ifa.pixel_tick_out, ifa.fetch_x_out, ifa.fetch_y_out}), 64'(0));
    @(posedge clk); #1;
    cmp("a_first_out", 64'({ifa.pixel_tick_out, ifa.frame_start_out, ifa.pixel_x_out, ifa.pixel_y_out,
                            ifa.video_on_out, ifa.pixel_out}),
        64'({1'b1, 1'b1, 10'd0, 9'd0, 1'b1, 12'hFFF}));
    cmp("a_fetch_lead", 64'({ifa.fetch_x_out, ifa.fetch_y_out}), 64'({10'd1, 9'd0}));
    for (int k = 0; k < 5000 && qa.size() != 0; k++) begin @(posedge clk); #1; end
    cmp("a_drain1", 64'(qa.size()), 64'(0));
    a_watch = 1'b0;
    cmp("a_pre_drop", 64'({ifa.pixel_x_out, ifa.pixel_y_out}), 64'({10'd100, 9'd2}));
    ifa.enable_in = 1'b0;
    @(posedge clk); #1;
    cmp("a_disable", outs_a(), RESET_OUTS);
    cmp("a_video_on_ticks", 64'(a_vo), 64'(1381));
    cmp("a_hsync_low_ticks", 64'(a_hs_lo), 64'(192));

    // ---- dut_a: restart from origin, then asynchronous reset mid-line
    @(negedge clk);
    for (int i = 0; i < 300; i++) qa.push_back(model(i, 800, 525, 640, 480, 656, 751, 490, 491, 320, 240));
    a_watch = 1'b1;
    ifa.enable_in = 1'b1;
    for (int k = 0; k < 2000 && qa.size() != 0; k++) begin @(posedge clk); #1; end
    cmp("a_drain2", 64'(qa.size()), 64'(0));
    a_watch = 1'b0;
    #2;
    rst_a = 1'b0;
    #1;
    cmp("a_async_reset", outs_a(), RESET_OUTS);
    ifa.enable_in = 1'b0;

    // ---- dut_b: CLK_DIV=1 scaled raster, two full frames
    @(negedge clk);
    for (int i = 0; i < 577; i++) qb.push_back(model(i, 24, 12, 16, 8, 18, 20, 9, 10, 8, 4));
    rst_b = 1'b1;
    ifb.enable_in = 1'b1;
    @(posedge clk); #1;
    cmp("b_first_out", 64'({ifb.pixel_tick_out, ifb.frame_start_out, ifb.pixel_x_out, ifb.pixel_y_out,
                            ifb.video_on_out, ifb.pixel_out}),
        64'({1'b1, 1'b1, 10'd0, 9'd0, 1'b1, 12'hFFF}));
    b_watch = 1'b1;
    for (int k = 0; k < 2000 && qb.size() != 0; k++) begin @(posedge clk); #1; end
    cmp("b_drain", 64'(qb.size()), 64'(0));
    b_watch = 1'b0;
    cmp("b_tick_every_clock", 64'(b_no_tick), 64'(0));
    cmp("b_frame_period", 64'(b_gap), 64'(288));
    cmp("b_vsync_low_ticks", 64'(b_vs_lo), 64'(48));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
